// File: rtl/wb_pkg.sv
// Shared types for the writeback pipeline: result-select encodings and the
// per-slot control record carried alongside the datapath fields.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_RSV = 2'd3
    } res_src_e;

    typedef struct packed {
        logic     valid;
        logic     reg_write;
        res_src_e result_src;
    } slot_ctrl_t;

    localparam slot_ctrl_t SLOT_CTRL_BUBBLE = '{valid: 1'b0, reg_write: 1'b0, result_src: RES_ALU};

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 4;

    // Writes to x0 and writes from bubbles must never reach the register file.
    function automatic logic gate_reg_write(input logic reg_write, input logic valid,
                                            input logic rd_nonzero);
        return reg_write & valid & rd_nonzero;
    endfunction

endpackage

// File: rtl/wb_slot.sv
// One M->W register slot: loads from its upstream neighbour, holds on stall,
// becomes a bubble on flush (flush wins over stall).
module wb_slot
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             stall_i,
    input  logic             flush_i,
    input  slot_ctrl_t       ctrl_i,
    input  logic [XLEN-1:0]  alu_i,
    input  logic [XLEN-1:0]  mem_i,
    input  logic [XLEN-1:0]  pc4_i,
    input  logic [RA_W-1:0]  rd_i,
    output slot_ctrl_t       ctrl_o,
    output logic [XLEN-1:0]  alu_o,
    output logic [XLEN-1:0]  mem_o,
    output logic [XLEN-1:0]  pc4_o,
    output logic [RA_W-1:0]  rd_o
);

    slot_ctrl_t      ctrl_d, ctrl_q;
    logic [XLEN-1:0] alu_d, alu_q, mem_d, mem_q, pc4_d, pc4_q;
    logic [RA_W-1:0] rd_d, rd_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        ctrl_d = ctrl_q;
        alu_d  = alu_q;
        mem_d  = mem_q;
        pc4_d  = pc4_q;
        rd_d   = rd_q;
        if (flush_i) begin
            ctrl_d = SLOT_CTRL_BUBBLE;
            alu_d  = '0;
            mem_d  = '0;
            pc4_d  = '0;
            rd_d   = '0;
        end else if (!stall_i) begin
            ctrl_d.valid      = ctrl_i.valid;
            ctrl_d.reg_write  = gate_reg_write(ctrl_i.reg_write, ctrl_i.valid, |rd_i);
            ctrl_d.result_src = ctrl_i.result_src;
            alu_d             = alu_i;
            mem_d             = mem_i;
            pc4_d             = pc4_i;
            rd_d              = rd_i;
        end
    end

    // NOTE: state uses non-blocking assignments; data fields are reset too because W outputs must read zero after reset.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ctrl_q <= SLOT_CTRL_BUBBLE;
            alu_q  <= '0;
            mem_q  <= '0;
            pc4_q  <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            alu_q  <= alu_d;
            mem_q  <= mem_d;
            pc4_q  <= pc4_d;
            rd_q   <= rd_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign alu_o  = alu_q;
    assign mem_o  = mem_q;
    assign pc4_o  = pc4_q;
    assign rd_o   = rd_q;

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback stage: DEPTH chained slots between M and W, the result select
// mux, and the retired-instruction counter.
module wb_pipe_stage
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int DEPTH = 1,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StallW,
    input  logic             FlushW,
    input  logic             ValidM,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic [XLEN-1:0]  ALUResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [RA_W-1:0]  RdM,
    output logic             ValidW,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [XLEN-1:0]  ALUResultW,
    output logic [XLEN-1:0]  ReadDataW,
    output logic [XLEN-1:0]  PCPlus4W,
    output logic [RA_W-1:0]  RdW,
    output logic [XLEN-1:0]  ResultW,
    output logic [CNT_W-1:0] InstRetW
);

    generate
        if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
            $error("wb_pipe_stage: DEPTH must be in 1..4");
        end
    endgenerate

    // Index 0 is the M-stage input; index k+1 is the output of slot k.
    slot_ctrl_t      ctrl_c [DEPTH+1];
    logic [XLEN-1:0] alu_c  [DEPTH+1];
    logic [XLEN-1:0] mem_c  [DEPTH+1];
    logic [XLEN-1:0] pc4_c  [DEPTH+1];
    logic [RA_W-1:0] rd_c   [DEPTH+1];

    assign ctrl_c[0] = slot_ctrl_t'{valid: ValidM, reg_write: RegWriteM,
                                    result_src: res_src_e'(ResultSrcM)};
    assign alu_c[0]  = ALUResultM;
    assign mem_c[0]  = ReadDataM;
    assign pc4_c[0]  = PCPlus4M;
    assign rd_c[0]   = RdM;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        wb_slot #(.XLEN(XLEN), .RA_W(RA_W)) u_slot (
            .CLK     (CLK),
            .RST     (RST),
            .stall_i (StallW),
            .flush_i (FlushW),
            .ctrl_i  (ctrl_c[k]),
            .alu_i   (alu_c[k]),
            .mem_i   (mem_c[k]),
            .pc4_i   (pc4_c[k]),
            .rd_i    (rd_c[k]),
            .ctrl_o  (ctrl_c[k+1]),
            .alu_o   (alu_c[k+1]),
            .mem_o   (mem_c[k+1]),
            .pc4_o   (pc4_c[k+1]),
            .rd_o    (rd_c[k+1])
        );
    end

    slot_ctrl_t ctrl_w;
    assign ctrl_w     = ctrl_c[DEPTH];
    assign ValidW     = ctrl_w.valid;
    assign RegWriteW  = ctrl_w.reg_write;
    assign ResultSrcW = ctrl_w.result_src;
    assign ALUResultW = alu_c[DEPTH];
    assign ReadDataW  = mem_c[DEPTH];
    assign PCPlus4W   = pc4_c[DEPTH];
    assign RdW        = rd_c[DEPTH];

    always_comb begin
        ResultW = '0;
        unique case (ctrl_w.result_src)
            RES_ALU: ResultW = ALUResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    // The W instruction commits on any non-stalled edge, including a flushing one.
    logic [CNT_W-1:0] inst_ret_d, inst_ret_q;

    always_comb begin
        inst_ret_d = inst_ret_q;
        if (ctrl_w.valid && (FlushW || !StallW)) begin
            inst_ret_d = inst_ret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            inst_ret_q <= '0;
        end else begin
            inst_ret_q <= inst_ret_d;
        end
    end

    assign InstRetW = inst_ret_q;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: a DEPTH=1/CNT_W=4 and a DEPTH=3/CNT_W=32 instance
// share stimulus and are checked every cycle against a queue-based model.
module tb_wb_pipe_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        StallW = 1'b0, FlushW = 1'b0, ValidM = 1'b0, RegWriteM = 1'b0;
    logic [1:0]  ResultSrcM = '0;
    logic [31:0] ALUResultM = '0, ReadDataM = '0, PCPlus4M = '0;
    logic [4:0]  RdM = '0;

    logic        v1, rw1, v3, rw3;
    logic [1:0]  src1, src3;
    logic [31:0] alu1, mem1, pc1, res1, alu3, mem3, pc3, res3;
    logic [4:0]  rd1, rd3;
    logic [3:0]  ir1;
    logic [31:0] ir3;

    wb_pipe_stage #(.XLEN(32), .RA_W(5), .DEPTH(1), .CNT_W(4)) u_d1 (
        .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .ValidW(v1), .RegWriteW(rw1), .ResultSrcW(src1), .ALUResultW(alu1),
        .ReadDataW(mem1), .PCPlus4W(pc1), .RdW(rd1), .ResultW(res1), .InstRetW(ir1)
    );

    wb_pipe_stage #(.XLEN(32), .RA_W(5), .DEPTH(3), .CNT_W(32)) u_d3 (
        .CLK(CLK), .RST(RST), .StallW(StallW), .FlushW(FlushW),
        .ValidM(ValidM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .ValidW(v3), .RegWriteW(rw3), .ResultSrcW(src3), .ALUResultW(alu3),
        .ReadDataW(mem3), .PCPlus4W(pc3), .RdW(rd3), .ResultW(res3), .InstRetW(ir3)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit        v;
        bit        rw;
        bit [1:0]  src;
        bit [31:0] alu;
        bit [31:0] mem;
        bit [31:0] pc4;
        bit [4:0]  rd;
    } rec_t;

    rec_t        q1[$];
    rec_t        q3[$];
    int unsigned cnt1, cnt3;
    bit          model_ok = 1'b0;

    function automatic rec_t bubble();
        rec_t r;
        r = '{v: 0, rw: 0, src: 0, alu: 0, mem: 0, pc4: 0, rd: 0};
        return r;
    endfunction

    function automatic rec_t from_m();
        rec_t r;
        r.v   = ValidM;
        r.rw  = RegWriteM && ValidM && (RdM != 0);
        r.src = ResultSrcM;
        r.alu = ALUResultM;
        r.mem = ReadDataM;
        r.pc4 = PCPlus4M;
        r.rd  = RdM;
        return r;
    endfunction

    function automatic bit [31:0] result_of(input rec_t r);
        case (r.src)
            2'd0:    return r.alu;
            2'd1:    return r.mem;
            2'd2:    return r.pc4;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_clear();
        q1.delete();
        q3.delete();
        q1.push_back(bubble());
        repeat (3) q3.push_back(bubble());
        cnt1 = 0;
        cnt3 = 0;
        model_ok = 1'b1;
    endtask

    // Queue head = newest instruction, tail = the one sitting in W.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            model_clear();
        end else begin
            if (FlushW || !StallW) begin
                if (q1[$].v) cnt1 = (cnt1 + 1) % 16;
                if (q3[$].v) cnt3 = cnt3 + 1;
            end
            if (FlushW) begin
                foreach (q1[i]) q1[i] = bubble();
                foreach (q3[i]) q3[i] = bubble();
            end else if (!StallW) begin
                q1.push_front(from_m());
                void'(q1.pop_back());
                q3.push_front(from_m());
                void'(q3.pop_back());
            end
        end
    end

    always @(negedge CLK) begin
        if (RST && model_ok) begin
            check("d1.ValidW",     v1,   q1[$].v);
            check("d1.RegWriteW",  rw1,  q1[$].rw);
            check("d1.ResultSrcW", src1, q1[$].src);
            check("d1.ALUResultW", alu1, q1[$].alu);
            check("d1.ReadDataW",  mem1, q1[$].mem);
            check("d1.PCPlus4W",   pc1,  q1[$].pc4);
            check("d1.RdW",        rd1,  q1[$].rd);
            check("d1.ResultW",    res1, result_of(q1[$]));
            check("d1.InstRetW",   ir1,  cnt1);
            check("d3.ValidW",     v3,   q3[$].v);
            check("d3.RegWriteW",  rw3,  q3[$].rw);
            check("d3.ResultSrcW", src3, q3[$].src);
            check("d3.ALUResultW", alu3, q3[$].alu);
            check("d3.ReadDataW",  mem3, q3[$].mem);
            check("d3.PCPlus4W",   pc3,  q3[$].pc4);
            check("d3.RdW",        rd3,  q3[$].rd);
            check("d3.ResultW",    res3, result_of(q3[$]));
            check("d3.InstRetW",   ir3,  cnt3);
        end
    end

    // ---------------- stimulus ----------------
    // Apply inputs, then return 2 time units after the edge that captures them.
    task automatic step(input bit v, input bit rw, input bit [1:0] src, input bit [31:0] alu,
                        input bit [31:0] mem, input bit [31:0] pc4, input bit [4:0] rd,
                        input bit stall, input bit flush);
        ValidM = v; RegWriteM = rw; ResultSrcM = src;
        ALUResultM = alu; ReadDataM = mem; PCPlus4M = pc4; RdM = rd;
        StallW = stall; FlushW = flush;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input bit stall, input bit flush);
        step(0, 0, 0, 32'h0, 32'h0, 32'h0, 5'd0, stall, flush);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".d1.ValidW"},   v1,   0);
        check({tag, ".d1.RegWriteW"}, rw1, 0);
        check({tag, ".d1.RdW"},      rd1,  0);
        check({tag, ".d1.ALUResultW"}, alu1, 0);
        check({tag, ".d1.ResultW"},  res1, 0);
        check({tag, ".d1.InstRetW"}, ir1,  0);
        check({tag, ".d3.ValidW"},   v3,   0);
        check({tag, ".d3.ResultSrcW"}, src3, 0);
        check({tag, ".d3.PCPlus4W"}, pc3,  0);
        check({tag, ".d3.ResultW"},  res3, 0);
        check({tag, ".d3.InstRetW"}, ir3,  0);
    endtask

    initial begin
        #1;
        check_all_zero("reset");
        idle(0, 0);
        idle(0, 0);
        RST = 1'b1;

        // Single ALU write to x5, then its retire count one cycle later.
        step(1, 1, 2'd0, 32'h0000_1234, 32'h0000_AAAA, 32'h0000_0104, 5'd5, 0, 0);
        check("lit.d1.RegWriteW", rw1, 1);
        check("lit.d1.RdW",       rd1, 5);
        check("lit.d1.ResultW",   res1, 32'h0000_1234);
        check("lit.d1.InstRetW0", ir1, 0);
        idle(0, 0);
        check("lit.d1.InstRetW1", ir1, 1);

        // Write to x0: valid but gated.
        step(1, 1, 2'd0, 32'h0000_0BAD, 32'h0, 32'h0000_0108, 5'd0, 0, 0);
        check("lit.x0.ValidW",    v1,  1);
        check("lit.x0.RegWriteW", rw1, 0);
        idle(0, 0);
        check("lit.x0.InstRetW",  ir1, 2);
        repeat (3) idle(0, 0);

        // A, B, C back to back with a two-cycle stall after B enters.
        step(1, 1, 2'd1, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3, 5'd1, 0, 0);
        step(1, 1, 2'd1, 32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3, 5'd2, 0, 0);
        step(1, 1, 2'd1, 32'h0000_00C1, 32'h0000_00C2, 32'h0000_00C3, 5'd3, 1, 0);
        step(1, 1, 2'd1, 32'h0000_00C1, 32'h0000_00C2, 32'h0000_00C3, 5'd3, 1, 0);
        step(1, 1, 2'd1, 32'h0000_00C1, 32'h0000_00C2, 32'h0000_00C3, 5'd3, 0, 0);
        check("lit.d3.A.RdW",     rd3, 1);
        check("lit.d3.A.ResultW", res3, 32'h0000_00A2);
        idle(0, 0);
        idle(0, 0);
        check("lit.d3.C.RdW",     rd3, 3);
        check("lit.d3.C.ResultW", res3, 32'h0000_00C2);

        // Stall and flush together: W instruction commits, everything else is dropped.
        step(1, 1, 2'd2, 32'h0000_00D1, 32'h0000_00D2, 32'h0000_00D3, 5'd4, 0, 0);
        check("lit.d1.D.ResultW", res1, 32'h0000_00D3);
        idle(1, 1);
        check("lit.flush.d1.ValidW",    v1,  0);
        check("lit.flush.d1.RegWriteW", rw1, 0);
        check("lit.flush.d3.ValidW",    v3,  0);
        check("lit.flush.d3.RegWriteW", rw3, 0);
        check("lit.flush.d1.InstRetW",  ir1, 6);
        check("lit.flush.d3.InstRetW",  ir3, 5);

        // Asynchronous reset mid-stream, away from any clock edge.
        step(1, 1, 2'd0, 32'h0000_0055, 32'h0000_0066, 32'h0000_0077, 5'd7, 0, 0);
        check("lit.pre_rst.d1.ValidW", v1, 1);
        #1;
        RST = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge CLK);
        #2;
        RST = 1'b1;

        // 17 retires on the 4-bit counter, with stalls and every result select.
        for (int i = 0; i < 17; i++) begin
            if (i % 5 == 3) begin
                step(1, 1, 2'd1, $urandom, $urandom, $urandom, 5'd9, 1, 0);
            end
            step(1, (i % 3) != 2, 2'(i % 4), $urandom, $urandom, $urandom, 5'(i), 0, 0);
        end
        repeat (3) idle(0, 0);
        check("lit.wrap.d1.InstRetW", ir1, 1);
        check("lit.wrap.d3.InstRetW", ir3, 17);

        idle(0, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
